// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial audio receiver.
// Oversamples the external bit clock with the system clock, deserialises the
// left/right slots MSB first and presents each completed stereo pair as two
// MSB-aligned signed 32-bit samples with a one-cycle valid strobe.
module i2s_rx #(
  parameter int DATA_WIDTH = 24
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i2s_bclk,
  input  logic               i2s_lrclk,
  input  logic               i2s_data,
  output logic signed [31:0] audio_out_L,
  output logic signed [31:0] audio_out_R,
  output logic               audio_valid,
  output logic               frame_error,
  output logic               locked
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } state_t;

  // Place a captured word in the top bits of a 32-bit sample, zero below,
  // so the word's MSB lands on the sign bit.
  function automatic logic signed [31:0] msb_align(input logic [DATA_WIDTH-1:0] w);
    logic [31:0] wide;
    wide = 32'(w);
    return signed'(wide << (32 - DATA_WIDTH));
  endfunction

  state_t                state;

  // Synchroniser chains: _p0 first flop, _p1 second flop.
  logic                  bclk_p0;
  logic                  bclk_p1;
  logic                  bclk_prev;
  logic                  ws_p0;
  logic                  ws_p1;
  logic                  din_p0;
  logic                  din_p1;

  logic                  ws_prev;
  logic [CNT_W-1:0]      bit_cnt;
  // Only DATA_WIDTH-1 bits need storing: the final bit of a word is taken
  // straight from the synchroniser in the rise cycle that completes it.
  logic [DATA_WIDTH-2:0] shift_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  valid_p0;

  logic                  rise;
  logic                  boundary;
  logic                  slot_full;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] word;

  assign rise      = bclk_p1 & ~bclk_prev;
  assign boundary  = rise & (ws_p1 != ws_prev);
  assign slot_full = (bit_cnt == CNT_FULL);
  assign last_bit  = rise & ~boundary & (bit_cnt == CNT_LAST);
  assign word      = {shift_reg, din_p1};

  // Two-flop synchronisers for the three I2S inputs plus the BCLK edge history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bclk_p0   <= 1'b0;
      bclk_p1   <= 1'b0;
      bclk_prev <= 1'b0;
      ws_p0     <= 1'b0;
      ws_p1     <= 1'b0;
      din_p0    <= 1'b0;
      din_p1    <= 1'b0;
    end else begin
      bclk_p0   <= i2s_bclk;
      bclk_p1   <= bclk_p0;
      bclk_prev <= bclk_p1;
      ws_p0     <= i2s_lrclk;
      ws_p1     <= ws_p0;
      din_p0    <= i2s_data;
      din_p1    <= din_p0;
    end
  end

  // Bit capture: the bit at a word-select change belongs to the previous
  // word (one-bit I2S delay) and is dropped; bits beyond DATA_WIDTH are padding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ws_prev   <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (rise) begin
      if (boundary) begin
        ws_prev <= ws_p1;
        bit_cnt <= '0;
      end else if (!slot_full) begin
        shift_reg <= word[DATA_WIDTH-2:0];
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  // Slot-tracking FSM; locked and frame_error are registered with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC_WAIT;
      locked      <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (boundary) begin
        case (state)
          SYNC_WAIT: begin
            if (!ws_p1) begin
              state  <= LEFT;
              locked <= 1'b1;
            end
          end
          LEFT, RIGHT: begin
            // A slot that ended before DATA_WIDTH bits voids the pair; a
            // short slot ending into a right slot cannot pair, so resync.
            if (!slot_full) begin
              frame_error <= 1'b1;
            end
            if (!ws_p1) begin
              state  <= LEFT;
              locked <= 1'b1;
            end else if (slot_full) begin
              state  <= RIGHT;
              locked <= 1'b1;
            end else begin
              state  <= SYNC_WAIT;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SYNC_WAIT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Left word holding register, loaded when the left slot fills.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg <= '0;
    end else if (last_bit && (state == LEFT)) begin
      hold_reg <= word;
    end
  end

  // Output stage: samples update with the last right bit, strobe follows one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      audio_out_L <= '0;
      audio_out_R <= '0;
      valid_p0    <= 1'b0;
      audio_valid <= 1'b0;
    end else begin
      valid_p0 <= 1'b0;
      if (last_bit && (state == RIGHT)) begin
        audio_out_L <= msb_align(hold_reg);
        audio_out_R <= msb_align(word);
        valid_p0    <= 1'b1;
      end
      // ---- strobe stage ----
      audio_valid <= valid_p0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized bench for i2s_rx with a slot-level reference model.
// Two receivers (24-bit and 16-bit) listen to the same I2S bus; each slot sent
// is fed to a per-width model that predicts pairs, errors and lock status.
`timescale 1ns/1ps
module tb_i2s_rx;

  logic clock = 1'b0;
  logic reset_n;
  logic bclk;
  logic lrclk;
  logic data;

  logic signed [31:0] l24, r24, l16, r16;
  logic v24, e24, k24, v16, e16, k16;

  always #5 clock = ~clock;

  i2s_rx #(.DATA_WIDTH(24)) dut24 (
    .clock(clock), .reset_n(reset_n), .i2s_bclk(bclk), .i2s_lrclk(lrclk),
    .i2s_data(data), .audio_out_L(l24), .audio_out_R(r24),
    .audio_valid(v24), .frame_error(e24), .locked(k24)
  );

  i2s_rx #(.DATA_WIDTH(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .i2s_bclk(bclk), .i2s_lrclk(lrclk),
    .i2s_data(data), .audio_out_L(l16), .audio_out_R(r16),
    .audio_valid(v16), .frame_error(e16), .locked(k16)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // ---------------- reference model (slot level) ----------------
  typedef struct {
    int          dut;
    logic [31:0] l;
    logic [31:0] r;
    int          ridx;
  } pair_t;

  pair_t       exp_q[$];
  int          width[2] = '{24, 16};
  int          m_st[2];      // 0 unsynced, 1 in left slot, 2 in right slot
  int          m_bits[2];    // data bits available in the current slot
  int          m_err[2];
  int          seen_err[2];
  logic        m_ws[2];
  logic [31:0] m_left[2];
  logic [31:0] last_l[2];
  logic [31:0] last_r[2];
  logic        pv[2];

  int cyc = 0;
  int rise_n = 0;
  int rise_cyc[8192];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] top_bits(input logic [31:0] p, input int w);
    return p & (32'hFFFF_FFFF << (32 - w));
  endfunction

  task automatic model_slot(input logic ws, input logic [31:0] payload, input int len);
    pair_t p;
    for (int d = 0; d < 2; d++) begin
      int w;
      w = width[d];
      if (ws != m_ws[d]) begin
        m_ws[d] = ws;
        if (m_st[d] != 0 && m_bits[d] < w) begin
          m_err[d]++;
          m_st[d] = ws ? 0 : 1;
        end else if (m_st[d] == 0) begin
          if (!ws) m_st[d] = 1;
        end else begin
          m_st[d] = ws ? 2 : 1;
        end
        m_bits[d] = len - 1;
        if (m_bits[d] >= w) begin
          if (m_st[d] == 1) begin
            m_left[d] = top_bits(payload, w);
          end else if (m_st[d] == 2) begin
            p.dut  = d;
            p.l    = m_left[d];
            p.r    = top_bits(payload, w);
            p.ridx = rise_n + w;
            exp_q.push_back(p);
            last_l[d] = p.l;
            last_r[d] = p.r;
          end
        end
      end else begin
        m_bits[d] += len;
      end
    end
  endtask

  function automatic logic [31:0] out_l(input int d);
    return (d == 0) ? l24 : l16;
  endfunction
  function automatic logic [31:0] out_r(input int d);
    return (d == 0) ? r24 : r16;
  endfunction

  // ---------------- stimulus ----------------
  // Slot of len BCLK periods: position 0 is the delayed bit of the previous
  // word, positions 1..32 carry payload MSB first, anything later is random.
  task automatic send_slot(input logic ws, input logic [31:0] payload, input int len);
    model_slot(ws, payload, len);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      bclk  = 1'b0;
      lrclk = ws;
      if (i >= 1 && i <= 32) data = payload[32 - i];
      else                   data = 1'($urandom_range(0, 1));
      repeat (5) @(negedge clock);
      bclk = 1'b1;
      rise_cyc[rise_n] = cyc;
      rise_n++;
      repeat (4) @(negedge clock);
    end
    check_eq("locked24", {31'b0, k24}, 32'(m_st[0] != 0));
    check_eq("locked16", {31'b0, k16}, 32'(m_st[1] != 0));
  endtask

  task automatic monitor(input int d, input logic v, input logic [31:0] l,
                         input logic [31:0] r, input logic e);
    int idx;
    if (e) seen_err[d]++;
    if (v) begin
      check_eq($sformatf("valid_consec%0d", width[d]), {31'b0, pv[d]}, 32'd0);
      idx = -1;
      foreach (exp_q[i]) if (idx < 0 && exp_q[i].dut == d) idx = i;
      if (idx < 0) begin
        check_eq($sformatf("valid_spurious%0d", width[d]), {31'b0, v}, 32'd0);
      end else begin
        check_eq($sformatf("pair_L%0d", width[d]), l, exp_q[idx].l);
        check_eq($sformatf("pair_R%0d", width[d]), r, exp_q[idx].r);
        check_eq($sformatf("latency%0d", width[d]), 32'(cyc - rise_cyc[exp_q[idx].ridx]), 32'd4);
        exp_q.delete(idx);
      end
    end
    pv[d] = v;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      monitor(0, v24, l24, r24, e24);
      monitor(1, v16, l16, r16, e16);
    end
  end

  task automatic phase_end(input string name);
    repeat (20) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      int n;
      n = 0;
      foreach (exp_q[i]) if (exp_q[i].dut == d) n++;
      check_eq($sformatf("%s_pending%0d", name, width[d]), 32'(n), 32'd0);
      check_eq($sformatf("%s_errors%0d", name, width[d]), 32'(seen_err[d]), 32'(m_err[d]));
      check_eq($sformatf("%s_holdL%0d", name, width[d]), out_l(d), last_l[d]);
      check_eq($sformatf("%s_holdR%0d", name, width[d]), out_r(d), last_r[d]);
    end
  endtask

  task automatic check_zero(input string name);
    check_eq({name, "_L24"}, l24, 32'd0);
    check_eq({name, "_R24"}, r24, 32'd0);
    check_eq({name, "_ctl24"}, {29'b0, v24, e24, k24}, 32'd0);
    check_eq({name, "_L16"}, l16, 32'd0);
    check_eq({name, "_R16"}, r16, 32'd0);
    check_eq({name, "_ctl16"}, {29'b0, v16, e16, k16}, 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clock);
    bclk    = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero(name);
    for (int d = 0; d < 2; d++) begin
      m_st[d]   = 0;
      m_bits[d] = 0;
      m_ws[d]   = 1'b0;
      last_l[d] = '0;
      last_r[d] = '0;
      pv[d]     = 1'b0;
    end
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    bclk    = 1'b0;
    lrclk   = 1'b0;
    data    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_bits[d] = 0; m_err[d] = 0; seen_err[d] = 0;
      m_ws[d] = 1'b0; m_left[d] = '0; last_l[d] = '0; last_r[d] = '0; pv[d] = 1'b0;
    end
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    // Start in the middle of a right slot, then a nominal frame.
    send_slot(1'b1, $urandom, 15);
    send_slot(1'b0, {24'h123456, 8'($urandom)}, 32);
    send_slot(1'b1, {24'hFEDCBA, 8'($urandom)}, 32);
    phase_end("nominal");
    check_eq("nominal_L_value", l24, 32'h12345600);
    check_eq("nominal_R_value", r24, 32'hFEDCBA00);

    // Full-scale negative / positive.
    send_slot(1'b0, {24'h800000, 8'($urandom)}, 32);
    send_slot(1'b1, {24'h7FFFFF, 8'($urandom)}, 32);
    phase_end("fullscale");
    check_eq("fullscale_L_value", l24, 32'h80000000);
    check_eq("fullscale_R_value", r24, 32'h7FFFFF00);

    // Short left slot (10 data bits), then a good frame.
    send_slot(1'b0, $urandom, 11);
    send_slot(1'b1, $urandom, 32);
    send_slot(1'b0, $urandom, 32);
    send_slot(1'b1, $urandom, 32);
    phase_end("short");

    // Reset in the middle of a left slot, then resync.
    send_slot(1'b0, $urandom, 32);
    send_slot(1'b1, $urandom, 32);
    send_slot(1'b0, $urandom, 9);
    do_reset("midreset");
    send_slot(1'b0, $urandom, 32);
    send_slot(1'b1, $urandom, 32);
    send_slot(1'b0, $urandom, 32);
    send_slot(1'b1, $urandom, 32);
    phase_end("after_reset");

    // Tight 16-bit slots, back to back.
    for (int f = 0; f < 4; f++) begin
      send_slot(1'b0, {16'hA5A5, 16'($urandom)}, 17);
      send_slot(1'b1, $urandom, 17);
    end
    phase_end("sweep16");
    check_eq("sweep16_L_value", l16, 32'hA5A50000);

    // Random slot lengths and payloads, including short slots.
    for (int f = 0; f < 40; f++) begin
      for (int s = 0; s < 2; s++) begin
        int r;
        int len;
        r = $urandom_range(0, 9);
        if (r == 0)      len = $urandom_range(2, 15);
        else if (r == 1) len = $urandom_range(17, 24);
        else             len = $urandom_range(25, 33);
        send_slot(1'(s), $urandom, len);
      end
    end
    phase_end("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 24: the number of audio bits captured per channel slot, legal range 8..32.
- REQ-002 SHALL have port clock, input, 1 bit: the system clock; all logic is rising-edge.
- REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL have port i2s_bclk, input, 1 bit: external bit clock, asynchronous to clock, period ≥ 8 clock cycles.
- REQ-005 SHALL have port i2s_lrclk, input, 1 bit: word select; 0 = left slot, 1 = right slot.
- REQ-006 SHALL have port i2s_data, input, 1 bit: serial data, MSB first.
- REQ-007 SHALL have port audio_out_L, output, signed 32 bits: left sample.
- REQ-008 SHALL have port audio_out_R, output, signed 32 bits: right sample.
- REQ-009 SHALL have port audio_valid, output, 1 bit: one-cycle strobe marking a new L/R pair.
- REQ-010 SHALL have port frame_error, output, 1 bit: one-cycle strobe marking a short slot.
- REQ-011 SHALL have port locked, output, 1 bit: high while in state LEFT or RIGHT.

Function
- REQ-012 SHALL synchronise i2s_bclk, i2s_lrclk and i2s_data each through an identical 2-flop chain.
- REQ-013 SHALL detect a BCLK rise in the cycle when synchronised bclk = 1 and its previous registered value = 0; all actions below occur only in rise cycles.
- REQ-014 SHALL, on each rise, sample the synchronised lrclk and data, and compare the sampled lrclk against ws_prev (its value at the previous rise).
- REQ-015 SHALL treat a rise where ws ≠ ws_prev as a boundary: the bit at that rise is discarded (I2S one-bit delay), bit_cnt is cleared to 0, and ws_prev is updated.
- REQ-016 SHALL, on a non-boundary rise with bit_cnt < DATA_WIDTH, shift the data bit into the shift register LSB-side and increment bit_cnt.
- REQ-017 SHALL, on a non-boundary rise with bit_cnt = DATA_WIDTH, ignore the bit (slot padding) and hold bit_cnt.
- REQ-018 SHALL implement an FSM with states SYNC_WAIT, LEFT and RIGHT, with the following transitions:
  - SYNC_WAIT→LEFT on a boundary with ws = 0.
  - LEFT→RIGHT on a boundary with ws = 1.
  - RIGHT→LEFT on a boundary with ws = 0.
  - All other rises: no state change.
- REQ-019 SHALL latch the left word into a holding register when bit_cnt reaches DATA_WIDTH in state LEFT.
- REQ-020 SHALL, when bit_cnt reaches DATA_WIDTH in state RIGHT, update audio_out_L from the holding register and audio_out_R from the shift register in the same cycle, and assert audio_valid for the following single cycle.
- REQ-021 SHALL MSB-align each word: output[31:32-DATA_WIDTH] = captured bits, with the remaining low bits = 0, so the sign is preserved.
- REQ-022 SHALL hold audio_out_L and audio_out_R between strobes.
- REQ-023 SHALL, on a boundary in LEFT or RIGHT where bit_cnt < DATA_WIDTH:
  - pulse frame_error for one cycle;
  - discard the pending pair, with no audio_valid for it;
  - go to LEFT if ws = 0, otherwise go to SYNC_WAIT.
- REQ-024 SHALL emit no audio_valid for a right slot unless a complete left slot of the same frame preceded it.
- REQ-025 SHALL drive audio_valid high for exactly one cycle per frame, never on consecutive cycles.
- REQ-026 SHALL keep latency from the detected rise carrying the last right bit to audio_valid high at 2 clock cycles (output register, then strobe).

Reset
- REQ-027 SHALL, while reset_n = 0, asynchronously clear:
  - the FSM to SYNC_WAIT;
  - bit_cnt, the shift and holding registers, ws_prev and all synchroniser flops to 0;
  - audio_out_L, audio_out_R, audio_valid, frame_error and locked to 0.
- REQ-028 SHALL, on reset mid-frame, discard the partial frame; the first audio_valid after release requires a new left boundary followed by a full left and full right slot.

Verification
- REQ-029 SHALL cover a nominal frame: DATA_WIDTH = 24, 32-bit slots, L = 24'h123456, R = 24'hFEDCBA → audio_valid once, audio_out_L = 32'h12345600, audio_out_R = 32'hFEDCBA00.
- REQ-030 SHALL cover a negative full-scale value: L = 24'h800000, R = 24'h7FFFFF → audio_out_L = 32'h80000000, audio_out_R = 32'h7FFFFF00.
- REQ-031 SHALL cover starting mid-right-slot after reset: first pair completes only after the next left boundary; the partial right slot produces no strobe; locked = 0 until that boundary.
- REQ-032 SHALL cover a short slot: the left slot ends after 10 bits → frame_error pulses once, no audio_valid for that frame, the next full frame outputs correctly.
- REQ-033 SHALL cover reset_n asserted mid-left-slot: all outputs read 0 immediately; after release, a complete frame yields correct values.
- REQ-034 SHALL cover a parameter sweep: DATA_WIDTH = 16 with a 16-bit slot of 16'hA5A5 → audio_out = 32'hA5A50000; back-to-back frames give one strobe per frame with no gaps or duplicates.
